multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Sequencing controller for converting the RV32I core from single-cycle to multi-cycle with one shared instruction/data memory port.
- Decodes opcode, Func_3 and Func_7 (instr[30]) and steps the datapath through fetch, decode, execute, memory and writeback.
- Drives all register enables, mux selects, ALU control and the memory request handshake.
- Sits between the instruction register and the datapath, replacing the combinational top-level control decoder.

Parameters:
- RESET_TRAP, 1, when 1 an illegal opcode parks the FSM in TRAP until reset; when 0 it is treated as a NOP and returns to FETCH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instr[6:0] from the instruction register
- Func_3  input  3  instr[14:12]
- Func_7  input  1  instr[30]
- zero  input  1  ALU result == 0
- lt  input  1  ALU signed less-than flag
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory access request, held until mem_ready
- mem_we  output  1  write strobe, valid with mem_req
- adr_src  output  1  0 = PC, 1 = ALU result register
- ir_write  output  1  load the instruction register
- pc_write  output  1  load PC
- reg_write  output  1  register file write enable
- alu_src_a  output  2  0 = PC, 1 = oldPC, 2 = rs1
- alu_src_b  output  2  0 = rs2, 1 = imm, 2 = const 4
- result_src  output  2  0 = ALU result register, 1 = memory data, 2 = ALU direct, 3 = imm (LUI)
- alu_ctrl  output  4  ALU operation, encoding from the package
- instr_retired  output  1  one-cycle pulse on the last cycle of every instruction
- illegal_instr  output  1  sticky flag, set on an undefined opcode

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to FETCH.
  - illegal_instr = 0.
  - All enables and mem_req deassert immediately.
  - Selects return to 0 and alu_ctrl returns to ADD.
  - Reset mid-access abandons the request with no retry.
- FETCH:
  - Drives mem_req = 1, adr_src = 0, alu_src_a = 0, alu_src_b = 2, alu_ctrl = ADD, result_src = 2.
  - Holds while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 in that same cycle (Mealy on mem_ready), then DECODE.
- DECODE: alu_src_a = 1, alu_src_b = 1, ADD (branch/jump target into the ALU result register). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI_WB
  - anything else -> TRAP (sets illegal_instr)
- EXEC_R: rs1 op rs2 -> ALU_WB.
- EXEC_I: rs1 op imm -> ALU_WB. Func_7 is used only for SRAI (Func_3 = 101); I-type with Func_3 = 000 is always ADD.
- ALU_WB: reg_write = 1, result_src = 0, instr_retired -> FETCH.
- MEM_ADR: rs1 + imm. Next state MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req = 1, adr_src = 1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write = 1, result_src = 1, instr_retired -> FETCH.
- MEM_WR: mem_req = 1, mem_we = 1, adr_src = 1. Holds until mem_ready; on mem_ready pulses instr_retired -> FETCH.
- BRANCH: rs1 - rs2 with SUB, result_src = 0. pc_write = taken, where taken is:
  - Func_3 000: zero
  - Func_3 001: !zero
  - Func_3 100: lt
  - Func_3 101: !lt
  - others: 0, treated as not taken
  - instr_retired, then FETCH.
- JAL: alu_src_a = 1, alu_src_b = 2, ADD; pc_write = 1, result_src = 0 -> ALU_WB (writes oldPC + 4).
- LUI_WB: reg_write = 1, result_src = 3, instr_retired -> FETCH.
- TRAP: all enables 0.
  - If RESET_TRAP = 1: stays in TRAP.
  - Otherwise: instr_retired -> FETCH.
- ALU decode for R/I ops (alu_op = FUNCT):
  - Func_3 000: ADD, or SUB when R-type and Func_7 = 1
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when Func_7 = 1
  - 110: OR
  - 111: AND
- Latency with mem_ready tied to 1: R/I = 4 cycles, load = 5, store = 4, branch = 3, JAL = 4, LUI = 3.
- Invariants:
  - mem_we is never 1 without mem_req.
  - reg_write and pc_write are never both 1, except in JAL.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum
  - opcode localparams
  - alu_ctrl_t encodings: ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5, SRL = 6, SRA = 7, OR = 8, AND = 9
  - alu_op_t (ADD, SUB, FUNCT)
  - src-select encodings
- One sub-module, alu_decoder: combinational alu_op/Func_3/Func_7/is_rtype -> alu_ctrl.

Test Plan:
- Reset: rst_n = 0 mid-MEM_RD with mem_req = 1 -> mem_req drops at once; after release the FSM is in FETCH, mem_req = 1, illegal_instr = 0.
- R-type SUB: opcode = 0110011, Func_3 = 000, Func_7 = 1, mem_ready = 1 -> FETCH, DECODE, EXEC_R (alu_ctrl = SUB), ALU_WB (reg_write = 1, instr_retired = 1); back in FETCH on cycle 5.
- Load with wait states: opcode = 0000011, mem_ready low for 3 cycles in MEM_RD -> mem_req and adr_src = 1 held for 4 cycles; MEM_WB asserts reg_write, result_src = 1.
- Branch: opcode = 1100011, Func_3 = 001, zero = 0 -> pc_write = 1 in BRANCH; same with zero = 1 -> pc_write = 0; each takes 3 cycles.
- Sweep: I-type opcode with all 8 Func_3 values × Func_7 = 0/1 -> alu_ctrl matches the decode table; ADDI with Func_7 = 1 still gives ADD.
- Illegal: opcode = 0100111, a store-like encoding with a bad bit -> TRAP; illegal_instr = 1 and sticky; no mem_req follows while RESET_TRAP = 1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state, opcode, ALU and mux-select encodings for the multi-cycle controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_LUI_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        AOP_ADD,
        AOP_SUB,
        AOP_FUNCT
    } alu_op_t;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;
    localparam logic [1:0] RES_IMM    = 2'd3;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// alu_decoder: maps the ALU operation class plus Func_3/Func_7 onto the ALU control code
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [2:0]  Func_3,
    input  logic        Func_7,
    input  logic        is_rtype,
    output alu_ctrl_t   alu_ctrl
);

    // Func_7 only selects SUB for register-register adds; for shifts it picks SRA in both formats
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (alu_op == AOP_SUB)
            alu_ctrl = ALU_SUB;
        else if (alu_op == AOP_FUNCT)
            case (Func_3)
                3'b000: alu_ctrl = (is_rtype && Func_7) ? ALU_SUB : ALU_ADD;
                3'b001: alu_ctrl = ALU_SLL;
                3'b010: alu_ctrl = ALU_SLT;
                3'b011: alu_ctrl = ALU_SLTU;
                3'b100: alu_ctrl = ALU_XOR;
                3'b101: alu_ctrl = Func_7 ? ALU_SRA : ALU_SRL;
                3'b110: alu_ctrl = ALU_OR;
                3'b111: alu_ctrl = ALU_AND;
            endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences the RV32I datapath through fetch/decode/execute/memory/writeback over one shared memory port
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit RESET_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] Func_3,
    input  logic       Func_7,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] alu_ctrl,
    output logic       instr_retired,
    output logic       illegal_instr
);

    state_t    state_q;
    logic      illegal_q;
    logic      taken;
    logic      is_rtype;
    alu_op_t   alu_op;
    alu_ctrl_t alu_ctrl_w;

    assign illegal_instr = illegal_q;
    assign alu_ctrl      = alu_ctrl_w;
    assign taken = (Func_3 == 3'b000) ? zero :
                   (Func_3 == 3'b001) ? !zero :
                   (Func_3 == 3'b100) ? lt :
                   (Func_3 == 3'b101) ? !lt : 1'b0;

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .Func_3   (Func_3),
        .Func_7   (Func_7),
        .is_rtype (is_rtype),
        .alu_ctrl (alu_ctrl_w)
    );

    // State sequencing and the sticky illegal-opcode flag; memory states wait on mem_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE:
                    case (opcode)
                        OP_R:               state_q <= S_EXEC_R;
                        OP_I:               state_q <= S_EXEC_I;
                        OP_LOAD, OP_STORE:  state_q <= S_MEM_ADR;
                        OP_BRANCH:          state_q <= S_BRANCH;
                        OP_JAL:             state_q <= S_JAL;
                        OP_LUI:             state_q <= S_LUI_WB;
                        default: begin
                            state_q   <= S_TRAP;
                            illegal_q <= 1'b1;
                        end
                    endcase
                S_EXEC_R, S_EXEC_I, S_JAL: state_q <= S_ALU_WB;
                S_MEM_ADR: state_q <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:  if (mem_ready) state_q <= S_MEM_WB;
                S_MEM_WR:  if (mem_ready) state_q <= S_FETCH;
                S_TRAP:    if (!RESET_TRAP) state_q <= S_FETCH;
                default:   state_q <= S_FETCH;
            endcase
        end
    end

    // Control outputs decoded from state; gated by rst_n so everything drops the instant reset asserts
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        instr_retired = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_src    = RES_ALUOUT;
        alu_op        = AOP_ADD;
        is_rtype      = 1'b0;
        if (rst_n)
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRC_B_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                end
                S_EXEC_R: begin
                    alu_src_a = SRC_A_RS1;
                    alu_op    = AOP_FUNCT;
                    is_rtype  = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = AOP_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEM_ADR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write     = 1'b1;
                    result_src    = RES_MEM;
                    instr_retired = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req       = 1'b1;
                    mem_we        = 1'b1;
                    adr_src       = 1'b1;
                    instr_retired = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a     = SRC_A_RS1;
                    alu_op        = AOP_SUB;
                    pc_write      = taken;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_FOUR;
                    pc_write  = 1'b1;
                end
                S_LUI_WB: begin
                    reg_write     = 1'b1;
                    result_src    = RES_IMM;
                    instr_retired = 1'b1;
                end
                S_TRAP: instr_retired = !RESET_TRAP;
                default: ;
            endcase
    end

endmodule
